// File: rtl/lib_frame_keep_ctrl_if.sv
// Command and beat channels of the frame keep controller.
// Valid/ready: a transfer happens on a rising edge where vld & rdy are both high; once raised, vld and its payload hold until that transfer.
interface lib_frame_keep_ctrl_if #(
    parameter int BYTE_W = 8,
    parameter int LEN_W  = 16
);
    logic              cmd_vld;
    logic              cmd_rdy;
    logic [LEN_W-1:0]  cmd_len;
    logic              beat_vld;
    logic              beat_rdy;
    logic              beat_sop;
    logic              beat_eop;
    logic [BYTE_W-1:0] beat_keep;

    modport master (
        output cmd_vld, cmd_len, beat_rdy,
        input  cmd_rdy, beat_vld, beat_sop, beat_eop, beat_keep
    );

    modport slave (
        input  cmd_vld, cmd_len, beat_rdy,
        output cmd_rdy, beat_vld, beat_sop, beat_eop, beat_keep
    );
endinterface

// File: rtl/lib_frame_keep_ctrl.sv
// Frame sequencer: turns one frame-length command into SOP/EOP-marked beats,
// full keep on every beat except the last, whose keep comes from the residual byte count.
module lib_frame_keep_ctrl #(
    parameter int BYTE_W = 8,
    parameter int LEN_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    lib_frame_keep_ctrl_if.slave  bus,
    output logic                  busy,
    output logic                  err_zero_len
);
    localparam int REM_W = $clog2(BYTE_W);
    localparam int CNT_W = LEN_W - REM_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic              sop_q, sop_d;
    logic              err_q, err_d;

    logic [LEN_W-1:0]  len_m1;
    logic [CNT_W-1:0]  load_cnt;
    logic [REM_W-1:0]  load_rem;
    logic              len_nz;
    logic              run;
    logic              last;
    logic              beat_hs;
    logic              cmd_hs;
    logic              load;
    logic [BYTE_W-1:0] keep;

    assign run      = (state_q == RUN);
    assign last     = run && (cnt_q == CNT_W'(1));
    assign len_nz   = |bus.cmd_len;
    // Only used when len_nz, so the wrap at zero never reaches a register.
    assign len_m1   = bus.cmd_len - LEN_W'(1);
    assign load_cnt = CNT_W'(len_m1 >> REM_W) + CNT_W'(1);
    assign load_rem = len_m1[REM_W-1:0];

    assign beat_hs  = run & bus.beat_rdy;
    // Accepting during the EOP transfer lets the next frame start with no bubble.
    assign bus.cmd_rdy = !run | (last & bus.beat_rdy);
    assign cmd_hs   = bus.cmd_vld & bus.cmd_rdy;
    assign load     = cmd_hs & len_nz;

    always_comb begin
        keep = '0;
        if (run) begin
            for (int i = 0; i < BYTE_W; i++) begin
                keep[i] = !last || (REM_W'(i) <= rem_q);
            end
        end
    end

    assign bus.beat_vld  = run;
    assign bus.beat_sop  = run & sop_q;
    assign bus.beat_eop  = last;
    assign bus.beat_keep = keep;
    assign busy          = run;
    assign err_zero_len  = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        sop_d   = sop_q;
        err_d   = cmd_hs & !len_nz;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = RUN;
                    cnt_d   = load_cnt;
                    rem_d   = load_rem;
                    sop_d   = 1'b1;
                end
            end
            RUN: begin
                if (beat_hs) begin
                    sop_d = 1'b0;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (last) begin
                        if (load) begin
                            cnt_d = load_cnt;
                            rem_d = load_rem;
                            sop_d = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            sop_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            sop_q   <= sop_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_lib_frame_keep_ctrl.sv
// Bench for lib_frame_keep_ctrl: directed and random frames, expected beats
// derived from frame length arithmetic and checked by a negedge monitor.
module tb_lib_frame_keep_ctrl;
    localparam int BYTE_W = 8;
    localparam int LEN_W  = 16;
    localparam int BUDGET = 500;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic err_zero_len;
    logic rand_rdy = 1'b0;
    logic chk_en = 1'b0;
    logic err_exp = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    // {sop, eop, keep}
    logic [BYTE_W+1:0] exp_q[$];

    lib_frame_keep_ctrl_if #(.BYTE_W(BYTE_W), .LEN_W(LEN_W)) bus ();

    lib_frame_keep_ctrl #(.BYTE_W(BYTE_W), .LEN_W(LEN_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .busy         (busy),
        .err_zero_len (err_zero_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Expected beats of a frame, computed from the byte count alone.
    task automatic push_frame(input int len);
        int nb;
        int left;
        logic [BYTE_W-1:0] k;
        nb = (len + BYTE_W - 1) / BYTE_W;
        for (int i = 0; i < nb; i++) begin
            left = len - i * BYTE_W;
            if (left >= BYTE_W) k = '1;
            else k = BYTE_W'((1 << left) - 1);
            exp_q.push_back({(i == 0), (i == nb - 1), k});
        end
    endtask

    always @(posedge clk) begin
        #1;
        bus.beat_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("beat_vld", 32'(bus.beat_vld), 32'(exp_q.size() != 0));
            check("busy", 32'(busy), 32'(exp_q.size() != 0));
            check("cmd_rdy", 32'(bus.cmd_rdy),
                  32'((exp_q.size() == 0) || (exp_q.size() == 1 && bus.beat_rdy)));
            check("err_zero_len", 32'(err_zero_len), 32'(err_exp));
            if (bus.beat_vld && exp_q.size() != 0) begin
                check("beat_sop", 32'(bus.beat_sop), 32'(exp_q[0][BYTE_W+1]));
                check("beat_eop", 32'(bus.beat_eop), 32'(exp_q[0][BYTE_W]));
                check("beat_keep", 32'(bus.beat_keep), 32'(exp_q[0][BYTE_W-1:0]));
                if (bus.beat_rdy) void'(exp_q.pop_front());
            end
            err_exp = 1'b0;
            if (rst) begin
                exp_q.delete();
            end else if (bus.cmd_vld && bus.cmd_rdy) begin
                if (bus.cmd_len == 0) err_exp = 1'b1;
                else push_frame(int'(bus.cmd_len));
            end
        end
    end

    task automatic send_cmd(input int len);
        bit done;
        done = 1'b0;
        bus.cmd_vld = 1'b1;
        bus.cmd_len = LEN_W'(len);
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (bus.cmd_rdy) begin
                done = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            tests_failed++;
            $display("FAIL cmd_accept: got no cmd_rdy expected accept len %0d", len);
        end
        @(posedge clk);
        #1;
        bus.cmd_vld = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.beat_vld) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            tests_failed++;
            $display("FAIL drain: got %0d beats pending expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.cmd_vld = 1'b0;
        bus.cmd_len = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        #1;
        check("reset_sop", 32'(bus.beat_sop), 32'd0);
        check("reset_eop", 32'(bus.beat_eop), 32'd0);
        check("reset_keep", 32'(bus.beat_keep), 32'd0);
        check("reset_cmd_rdy", 32'(bus.cmd_rdy), 32'd1);
        @(posedge clk);
        #1;

        send_cmd(1);
        wait_idle();
        send_cmd(20);
        wait_idle();
        send_cmd(8);
        wait_idle();

        // Back-to-back: second command waits for the EOP transfer.
        send_cmd(9);
        send_cmd(3);
        wait_idle();

        rand_rdy = 1'b1;
        send_cmd(20);
        wait_idle();
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;

        send_cmd(0);
        send_cmd(2);
        wait_idle();

        // Reset after two beats; a command in the reset cycle must be ignored.
        send_cmd(40);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.cmd_vld = 1'b1;
        bus.cmd_len = LEN_W'(5);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.cmd_vld = 1'b0;
        check("rst_beat_vld", 32'(bus.beat_vld), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        send_cmd(16);
        wait_idle();

        rand_rdy = 1'b1;
        for (int f = 0; f < 40; f++) begin
            send_cmd(($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 40)));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        wait_idle();
        rand_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("final_queue", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
